// File: rtl/mem_port_arbiter.sv
`timescale 1ns / 1ps
// mem_port_arbiter
// Shares one single-port, multi-cycle unified memory between the instruction
// fetch port and the data port. Requests are serialised with data having
// priority over fetch. The block drives the memory handshake, returns read data
// to the granted port, and produces the pipeline stall. A BUSY watchdog forces
// completion if the memory never acknowledges.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64   // must be >= 2
) (
    input  logic              clk_i,
    input  logic              rst_i,       // asynchronous, active low

    // Instruction fetch port
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,

    // Data port
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,

    // Pipeline freeze
    output logic              stall_o,

    // Memory side
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,

    output logic              err_o
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Counter value that marks the last BUSY cycle allowed without an ack.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              if_ready_q,  if_ready_d;
    logic              d_ready_q,   d_ready_d;
    logic              err_q,       err_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;

    // Next-state logic: arbitration, handshake tracking, capture and timeout.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block from inferring latches.
        state_d     = state_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        err_d       = err_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            IDLE: begin
                // Data wins: it belongs to the older instruction in the pipe.
                if (d_req_i) begin
                    state_d     = BUSY_D;
                    mem_en_d    = 1'b1;
                    mem_we_d    = d_we_i;
                    mem_addr_d  = d_addr_i;
                    mem_wdata_d = d_wdata_i;
                    cnt_d       = '0;
                end else if (if_req_i) begin
                    state_d     = BUSY_IF;
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    cnt_d       = '0;
                end
            end

            BUSY_IF, BUSY_D: begin
                if (mem_ack_i) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata_i;
                        if_ready_d = 1'b1;
                    end else begin
                        // A store returns nothing; keep the last load value.
                        if (!mem_we_q) d_rdata_d = mem_rdata_i;
                        d_ready_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Memory never answered: complete with zero data and flag it.
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    err_d    = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                // Ready is visible this cycle; requesters retire their req at
                // the closing edge, so no arbitration happens here.
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Registered outputs.
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign d_ready_o   = d_ready_q;
    assign err_o       = err_q;

    // Freeze the pipeline while any request is pending and not yet completed.
    assign stall_o = (d_req_i & ~d_ready_q) | (if_req_i & ~if_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns / 1ps
// tb_mem_port_arbiter
// Directed bench: the memory handshake is driven by hand, inputs change and
// outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic              clk_i;
    logic              rst_i;
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              d_req_i;
    logic              d_we_i;
    logic [ADDR_W-1:0] d_addr_i;
    logic [DATA_W-1:0] d_wdata_i;
    logic [DATA_W-1:0] d_rdata_o;
    logic              d_ready_o;
    logic              stall_o;
    logic              mem_en_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .if_req_i   (if_req_i),
        .if_addr_i  (if_addr_i),
        .if_rdata_o (if_rdata_o),
        .if_ready_o (if_ready_o),
        .d_req_i    (d_req_i),
        .d_we_i     (d_we_i),
        .d_addr_i   (d_addr_i),
        .d_wdata_i  (d_wdata_i),
        .d_rdata_o  (d_rdata_o),
        .d_ready_o  (d_ready_o),
        .stall_o    (stall_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .mem_ack_i  (mem_ack_i),
        .err_o      (err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Safety net so the run always ends on its own.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst_i       = 1'b0;
        if_req_i    = 1'b0;
        if_addr_i   = '0;
        d_req_i     = 1'b0;
        d_we_i      = 1'b0;
        d_addr_i    = '0;
        d_wdata_i   = '0;
        mem_rdata_i = '0;
        mem_ack_i   = 1'b0;

        // ---------------- Reset state ----------------
        step(); step();
        check("rst_mem_en",   {31'b0, mem_en_o},   32'h0);
        check("rst_mem_addr", mem_addr_o,          32'h0);
        check("rst_if_rdata", if_rdata_o,          32'h0);
        check("rst_d_rdata",  d_rdata_o,           32'h0);
        check("rst_readys",   {30'b0, if_ready_o, d_ready_o}, 32'h0);
        check("rst_err",      {31'b0, err_o},      32'h0);
        rst_i = 1'b1;
        step();

        // ---------------- Single fetch, ack 3 cycles after mem_en ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h10;
        step();
        check("f_mem_en",   {31'b0, mem_en_o}, 32'h1);
        check("f_mem_addr", mem_addr_o,        32'h10);
        check("f_mem_we",   {31'b0, mem_we_o}, 32'h0);
        check("f_stall",    {31'b0, stall_o},  32'h1);
        step(); step(); step();
        check("f_en_held",  {31'b0, mem_en_o}, 32'h1);
        check("f_no_ready", {31'b0, if_ready_o}, 32'h0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h0050_0093;
        step();
        check("f_ready",    {31'b0, if_ready_o}, 32'h1);
        check("f_rdata",    if_rdata_o,          32'h0050_0093);
        check("f_stall_lo", {31'b0, stall_o},    32'h0);
        check("f_en_drop",  {31'b0, mem_en_o},   32'h0);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        step();
        check("f_ready_1cyc", {31'b0, if_ready_o}, 32'h0);
        check("f_idle_en",    {31'b0, mem_en_o},   32'h0);

        // ---------------- Simultaneous fetch + load: data first ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h44;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h200;
        step();
        check("s_d_addr",  mem_addr_o,        32'h200);
        check("s_d_we",    {31'b0, mem_we_o}, 32'h0);
        check("s_stall1",  {31'b0, stall_o},  32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1234_5678;
        step();
        check("s_d_ready",  {31'b0, d_ready_o},  32'h1);
        check("s_if_nordy", {31'b0, if_ready_o}, 32'h0);
        check("s_d_rdata",  d_rdata_o,           32'h1234_5678);
        check("s_stall2",   {31'b0, stall_o},    32'h1);
        mem_ack_i = 1'b0;
        d_req_i   = 1'b0;
        step();
        check("s_idle_en",  {31'b0, mem_en_o},  32'h0);
        check("s_stall3",   {31'b0, stall_o},   32'h1);
        step();
        check("s_if_en",    {31'b0, mem_en_o},  32'h1);
        check("s_if_addr",  mem_addr_o,         32'h44);
        check("s_stall4",   {31'b0, stall_o},   32'h1);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hCAFE_F00D;
        step();
        check("s_if_ready", {31'b0, if_ready_o}, 32'h1);
        check("s_if_rdata", if_rdata_o,          32'hCAFE_F00D);
        check("s_stall_lo", {31'b0, stall_o},    32'h0);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        step();

        // ---------------- Store, ack after one cycle ----------------
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_addr_i  = 32'h40;
        d_wdata_i = 32'hDEAD_BEEF;
        step();
        check("st_we",    {31'b0, mem_we_o}, 32'h1);
        check("st_wdata", mem_wdata_o,       32'hDEAD_BEEF);
        check("st_addr",  mem_addr_o,        32'h40);
        step();
        check("st_we_hold",    {31'b0, mem_we_o}, 32'h1);
        check("st_wdata_hold", mem_wdata_o,       32'hDEAD_BEEF);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'hFFFF_0000;
        step();
        check("st_ready", {31'b0, d_ready_o}, 32'h1);
        check("st_rdata_kept", d_rdata_o,    32'h1234_5678);
        check("st_en_drop", {31'b0, mem_en_o}, 32'h0);
        mem_ack_i = 1'b0;
        d_req_i   = 1'b0;
        d_we_i    = 1'b0;
        step();

        // ---------------- Timeout on a fetch ----------------
        if_req_i  = 1'b1;
        if_addr_i = 32'h80;
        for (int i = 0; i < TIMEOUT; i++) begin
            step();
            check($sformatf("t_busy_en%0d", i),  {31'b0, mem_en_o},   32'h1);
            check($sformatf("t_busy_err%0d", i), {31'b0, err_o},      32'h0);
            check($sformatf("t_busy_rdy%0d", i), {31'b0, if_ready_o}, 32'h0);
        end
        step();
        check("t_err",    {31'b0, err_o},      32'h1);
        check("t_ready",  {31'b0, if_ready_o}, 32'h1);
        check("t_rdata0", if_rdata_o,          32'h0);
        check("t_en_drop",{31'b0, mem_en_o},   32'h0);
        if_req_i = 1'b0;
        step();
        // Normal fetch after timeout: err stays sticky.
        if_req_i  = 1'b1;
        if_addr_i = 32'h84;
        step();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h00A0_0113;
        step();
        check("t2_ready", {31'b0, if_ready_o}, 32'h1);
        check("t2_rdata", if_rdata_o,          32'h00A0_0113);
        check("t2_err",   {31'b0, err_o},      32'h1);
        mem_ack_i = 1'b0;
        if_req_i  = 1'b0;
        step();
        check("t3_err",   {31'b0, err_o},      32'h1);

        // ---------------- Spurious ack in IDLE ----------------
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5555_5555;
        step();
        check("sp_i_en",     {31'b0, mem_en_o}, 32'h0);
        check("sp_i_readys", {30'b0, if_ready_o, d_ready_o}, 32'h0);
        check("sp_i_ifrd",   if_rdata_o, 32'h00A0_0113);
        check("sp_i_drd",    d_rdata_o,  32'h1234_5678);
        mem_ack_i = 1'b0;
        step();

        // ---------------- Spurious ack in DONE ----------------
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h204;
        step();
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        step();
        check("sp_d_ready", {31'b0, d_ready_o}, 32'h1);
        check("sp_d_rdata", d_rdata_o,          32'h1111_2222);
        mem_rdata_i = 32'h9999_9999;   // ack still high during DONE
        d_req_i     = 1'b0;
        step();
        check("sp_d_kept",  d_rdata_o,          32'h1111_2222);
        check("sp_d_en",    {31'b0, mem_en_o},  32'h0);
        check("sp_d_rdy0",  {31'b0, d_ready_o}, 32'h0);
        mem_ack_i = 1'b0;
        step();
        check("sp_d_idle",  {31'b0, mem_en_o},  32'h0);

        // ---------------- Asynchronous reset mid BUSY_D ----------------
        d_req_i  = 1'b1;
        d_addr_i = 32'h300;
        step();
        check("r_busy_en", {31'b0, mem_en_o}, 32'h1);
        #2 rst_i = 1'b0;
        #1;
        check("r_en_async",  {31'b0, mem_en_o}, 32'h0);
        check("r_readys",    {30'b0, if_ready_o, d_ready_o}, 32'h0);
        check("r_err_clr",   {31'b0, err_o},    32'h0);
        check("r_rdata_clr", d_rdata_o,         32'h0);
        check("r_addr_clr",  mem_addr_o,        32'h0);
        d_req_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        check("r_post_en",  {31'b0, mem_en_o}, 32'h0);
        check("r_post_rdy", {30'b0, if_ready_o, d_ready_o}, 32'h0);
        step();
        check("r_post_rdy2", {30'b0, if_ready_o, d_ready_o}, 32'h0);
        check("r_post_err",  {31'b0, err_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, multi-cycle unified memory between the instruction-fetch port (IF) and the data port (MEM stage).
- Serialises the requests, drives the memory handshake and returns read data to whichever port was granted.
- Produces the pipeline stall that freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB while any access is outstanding.
- Sits between the CPU core and the memory model, replacing direct Instruction_Memory/Data_Memory wiring.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, max BUSY cycles waiting for mem_ack_i before forced completion (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-low reset
if_req_i  in  1  fetch request; held stable until if_ready_o
if_addr_i  in  ADDR_W  fetch address (PC)
if_rdata_o  out  DATA_W  fetched instruction
if_ready_o  out  1  one-cycle completion pulse for fetch
d_req_i  in  1  data request; held stable until d_ready_o
d_we_i  in  1  1=store, 0=load
d_addr_i  in  ADDR_W  data address (ALU result)
d_wdata_i  in  DATA_W  store data
d_rdata_o  out  DATA_W  load data
d_ready_o  out  1  one-cycle completion pulse for data
stall_o  out  1  pipeline freeze
mem_en_o  out  1  memory request, held until ack
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with ack
mem_ack_i  in  1  one-cycle completion from memory
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, async): state=IDLE; all outputs 0, including rdata registers, err_o and the timeout counter.
- A reset mid-transaction abandons it: mem_en_o drops immediately and no ready pulse is ever issued.
- FSM states: IDLE, BUSY_IF, BUSY_D, DONE.
- IDLE arbitration, fixed priority, data over fetch (the data access belongs to the older instruction):
  - d_req_i=1 -> BUSY_D; latch d_addr_i, d_wdata_i, d_we_i into mem_* registers.
  - else if_req_i=1 -> BUSY_IF; latch if_addr_i, mem_we_o=0, mem_wdata_o=0.
  - else stay in IDLE.
- All outputs except stall_o are registered.
- mem_en_o=1 for the whole of BUSY_*; mem_addr_o, mem_we_o and mem_wdata_o stay constant while busy.
- BUSY_* and mem_ack_i=1:
  - capture mem_rdata_i into if_rdata_o (BUSY_IF) or d_rdata_o (BUSY_D load only; a store leaves d_rdata_o unchanged);
  - next state DONE; mem_en_o=0 from the next cycle.
- DONE: exactly one cycle; the granted port's ready=1; no arbitration; next state IDLE.
- Requesters change or drop req at the edge that ends the ready cycle, so a still-high req during DONE is never re-issued.
- Minimum latency: req seen at edge N -> mem_en_o high in cycle N+1 -> ack earliest in N+1 -> ready in cycle N+2.
- Timeout:
  - the counter clears on entering BUSY_* and increments each BUSY cycle without ack;
  - at TIMEOUT cycles: set err_o (sticky until reset), write 0 to the granted rdata register, go to DONE, drop mem_en_o.
- mem_ack_i in IDLE or DONE is ignored.
- Requester drops req while busy: the transaction still completes and ready still pulses.
- rdata outputs hold their last value until the next completion on that port.
- stall_o, combinational: (d_req_i & ~d_ready_o) | (if_req_i & ~if_ready_o).
- Pipeline consequence: a cycle-accurate fetch with a simultaneous load stalls for both accesses back to back, data first.

Test Plan:
- Reset: rst_i=0 asynchronously mid-BUSY_D -> mem_en_o, stall-relevant ready outputs and err_o go 0 immediately; state IDLE after release, no ready pulse.
- Single fetch: if_req_i=1, if_addr_i=0x10, memory acks 3 cycles after mem_en_o with 0x00500093 -> mem_addr_o=0x10, if_rdata_o=0x00500093, if_ready_o high one cycle, stall_o low in that cycle.
- Simultaneous requests: if_req_i and d_req_i (load 0x200) rise together -> data served first (mem_addr_o=0x200), d_ready_o pulses, then fetch issued; stall_o continuous until if_ready_o.
- Store: d_req_i=1, d_we_i=1, addr 0x40, wdata 0xDEADBEEF, ack after 1 cycle -> mem_we_o=1, mem_wdata_o=0xDEADBEEF stable until ack; d_rdata_o unchanged.
- Timeout: TIMEOUT=8, no ack -> after 8 BUSY cycles err_o=1, if_rdata_o=0, if_ready_o pulses; err_o stays 1 across later normal accesses.
- Spurious ack: mem_ack_i pulsed in IDLE and in DONE -> no state change, no rdata update.
